sr_flipflop_bank: RTL
=====================

# sr_flipflop_bank

Parametrised, clocked successor to the single-bit SR latch. It provides WIDTH independent edge-triggered SR storage bits that share one clock and one enable. The S=R=1 case resolves deterministically according to a MODE parameter, and every bit always keeps Q_not equal to ~Q. It also reports per-bit change pulses, sticky conflict flags, and a saturating conflict counter, which lab boards use for status registers and for exercising bounce/conflict behaviour.

## Interface
Parameters:
- WIDTH, 8, number of SR bits (1..32)
- MODE, 0, S=R=1 resolution: 0 hold, 1 set-priority, 2 reset-priority, 3 toggle
- CNT_W, 4, width of conflict_count (1..16)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- EN  input  1  bank enable; 0 freezes Q and suppresses all event recording
- S  input  WIDTH  per-bit set request
- R  input  WIDTH  per-bit reset request
- clr_conflict  input  1  clears conflict_flag and conflict_count
- Q  output  WIDTH  stored state
- Q_not  output  WIDTH  always exactly ~Q, including in reset
- changed  output  WIDTH  one-cycle pulse on each bit whose Q changed at this edge
- conflict_flag  output  WIDTH  sticky per-bit flag; set when that bit saw S=R=1 with EN=1
- conflict_count  output  CNT_W  saturating count of enabled cycles with any bit in conflict

## Operation
- Per-bit next state when EN=1:
  - S=0,R=0 -> hold
  - S=1,R=0 -> 1
  - S=0,R=1 -> 0
  - S=1,R=1 -> per MODE: hold / 1 / 0 / ~Q
- EN=0: Q holds for all bits; changed=0; conflict_flag and conflict_count are not updated by S/R.
- changed[i] is registered as (Q_next[i] != Q[i]). It is high for the one cycle after the edge at which Q changed.
- Conflict recording: conflict_vec = S & R & {WIDTH{EN}}.
- conflict_flag update: conflict_flag <= clr_conflict ? conflict_vec : (conflict_flag | conflict_vec). A conflict in the same cycle as a clear is therefore retained.
- conflict_count update:
  - clr_conflict=1 -> count becomes (|conflict_vec ? 1 : 0)
  - otherwise, +1 when |conflict_vec, saturating at 2^CNT_W-1; no wrap
  - one increment per cycle, regardless of how many bits conflict
- clr_conflict is honoured regardless of EN.
- The S=R=1 "both outputs low" latch state does not exist in this block; Q_not is never derived independently.

## Timing
- Reset (rst_n=0 at a rising edge): Q=0, Q_not=all ones, changed=0, conflict_flag=0, conflict_count=0.
  - Reset overrides EN, S, R and clr_conflict.
  - Reset asserted mid-operation takes effect at the next edge with no partial update.
- Latency: S/R/EN/clr_conflict sampled at edge k are visible on all outputs after edge k; the latency is one cycle.
- No combinational path from inputs to outputs; all outputs are registered.
- First edge after reset release (rst_n=1) processes S/R normally; changed can pulse on that cycle.
- MODE 3 with S=R=1 held for N enabled cycles: Q toggles every cycle and changed stays high for those cycles.

## Structure
- Shared package sr_bank_pkg:
  - MODE_HOLD=0, MODE_SET=1, MODE_RESET=2, MODE_TOGGLE=3
  - a function sr_next(q, s, r, mode) returning the next bit state
- Sub-module sr_cell: a single bit holding the Q register and changed register, generated WIDTH times.
- Conflict flags and counter stay in the top level.
- Elaboration-time check rejects MODE>3 and any WIDTH or CNT_W outside its range.

## Test plan
WIDTH=4, CNT_W=2 unless noted.
- Reset: rst_n=0 for 2 cycles with S=4'hF, EN=1 -> Q=0, Q_not=4'hF, changed=0, flags=0, count=0.
- Basic set/reset, MODE=0: EN=1, S=4'b0101, R=0 -> next cycle Q=0101, changed=0101. Then S=0, R=4'b0001 -> Q=0100, changed=0001. Then S=R=0 -> Q=0100, changed=0.
- Conflict modes, S=R=4'b0011 from Q=0001:
  - MODE 0 -> Q=0001
  - MODE 1 -> Q=0011
  - MODE 2 -> Q=0000
  - MODE 3 -> Q=0010, then 0001 on the next cycle
  - in every case conflict_flag=0011
- Saturation and clear: S=R=4'b1000 for 5 enabled cycles -> count 1,2,3,3,3. Then clr_conflict=1 with S=R=0 -> flags=0, count=0. Then clr_conflict=1 together with S=R=4'b0100 -> flags=0100, count=1.
- Enable gating: EN=0, S=R=4'hF for 3 cycles -> Q unchanged, changed=0, flags and count unchanged.
- Reset mid-stream: MODE 3 toggling under S=R=1, rst_n=0 for one edge -> all outputs at reset values on the next cycle. rst_n=1 with S=R=0 -> Q stays 0.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flip-flop bank: S=R=1 resolution modes and
// the per-bit next-state function.
package sr_bank_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_SET    = 2'd1;
    localparam logic [1:0] MODE_RESET  = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input logic [1:0] mode);
        logic n;
        unique case ({s, r})
            2'b00: n = q;
            2'b10: n = 1'b1;
            2'b01: n = 1'b0;
            default: begin
                unique case (mode)
                    MODE_HOLD:   n = q;
                    MODE_SET:    n = 1'b1;
                    MODE_RESET:  n = 1'b0;
                    default:     n = ~q;
                endcase
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One edge-triggered SR storage bit with a registered change pulse.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter logic [1:0] MODE_SEL = MODE_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic changed
);

    logic q_q;
    logic q_d;
    logic changed_q;

    assign q_d = en ? sr_next(q_q, s, r, MODE_SEL) : q_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= q_d ^ q_q;
        end
    end

    assign q       = q_q;
    assign changed = changed_q;

endmodule

// File: rtl/sr_flipflop_bank.sv
// Bank of WIDTH clocked SR bits with shared enable, sticky conflict flags and a
// saturating count of enabled cycles that saw any S=R=1 conflict.
module sr_flipflop_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_not,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict_flag,
    output logic [CNT_W-1:0] conflict_count
);

    if (MODE > 3) begin : g_bad_mode
        $error("sr_flipflop_bank: MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sr_flipflop_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("sr_flipflop_bank: CNT_W must be 1..16");
    end

    localparam logic [1:0]       ModeSel = MODE[1:0];
    localparam logic [CNT_W-1:0] CntMax  = '1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE_SEL (ModeSel)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (EN),
            .s       (S[i]),
            .r       (R[i]),
            .q       (Q[i]),
            .changed (changed[i])
        );
    end

    // Q_not is an inverter on the stored bit, so it can never disagree with Q.
    assign Q_not = ~Q;

    logic [WIDTH-1:0] conflict_vec;
    logic             any_conflict;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign conflict_vec = S & R & {WIDTH{EN}};
    assign any_conflict = |conflict_vec;

    always_comb begin
        flag_d  = flag_q | conflict_vec;
        count_d = count_q;
        if (clr_conflict) begin
            // A conflict arriving with the clear is kept rather than lost.
            flag_d  = conflict_vec;
            count_d = CNT_W'(any_conflict);
        end else if (any_conflict && count_q != CntMax) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q  <= '0;
            count_q <= '0;
        end else begin
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign conflict_flag  = flag_q;
    assign conflict_count = count_q;

endmodule
